// File: rtl/heater_sequencer.sv
// Heater enable sequencer: staggers enable rises to limit inrush and recovers
// heater errors with timed err_clear pulses, latching a fault after RETRY_MAX recoveries.
module heater_sequencer #(
  parameter int N            = 16,
  parameter int STEP_CYCLES  = 1024,
  parameter int CLEAR_CYCLES = 4,
  parameter int RETRY_MAX    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_enable,
  input  logic [N-1:0]           heater_error,
  input  logic                   sticky_clr,
  output logic [N-1:0]           heater_enable,
  output logic [N-1:0]           heater_err_clear,
  output logic [N-1:0]           fault,
  output logic [N-1:0]           error_sticky,
  output logic [$clog2(N+1)-1:0] active_count,
  output logic                   busy
);

  localparam int TMAX = (STEP_CYCLES > CLEAR_CYCLES) ? STEP_CYCLES : CLEAR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(RETRY_MAX + 1);
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = $clog2(N + 1);

  typedef enum logic       {R_IDLE, R_WAIT} ramp_t;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_DONE} clr_t;

  ramp_t          ramp_state;
  clr_t           clr_state;
  logic [TW-1:0]  ramp_timer;
  logic [TW-1:0]  clr_timer;
  logic [IW-1:0]  clr_idx;
  logic [N-1:0]   clr_pend;
  logic [RW-1:0]  retry [N];

  logic [N-1:0]   eligible;
  logic           ramp_any;
  logic [IW-1:0]  ramp_k;
  logic           pend_any;
  logic [IW-1:0]  pend_k;
  logic [CW-1:0]  en_count;
  logic           ramp_fire;
  logic [RW-1:0]  retry_next;

  always_comb begin
    eligible = req_enable & ~heater_enable & ~fault & ~clr_pend;
    ramp_any = 1'b0;
    ramp_k   = '0;
    pend_any = 1'b0;
    pend_k   = '0;
    en_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i] && !ramp_any) begin
        ramp_any = 1'b1;
        ramp_k   = IW'(i);
      end
      if (clr_pend[i] && !pend_any) begin
        pend_any = 1'b1;
        pend_k   = IW'(i);
      end
      en_count = en_count + CW'(heater_enable[i]);
    end
    // An expiring R_WAIT issues the next rise directly, keeping rises exactly
    // STEP_CYCLES apart; with nothing eligible it drops back to R_IDLE.
    ramp_fire  = ramp_any && (ramp_state == R_IDLE || ramp_timer == '0);
    retry_next = (retry[clr_idx] < RW'(RETRY_MAX)) ? retry[clr_idx] + 1'b1 : retry[clr_idx];
  end

  assign busy = (ramp_state != R_IDLE) || (clr_state != C_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      heater_enable    <= '0;
      heater_err_clear <= '0;
      fault            <= '0;
      error_sticky     <= '0;
      active_count     <= '0;
      clr_pend         <= '0;
      ramp_state       <= R_IDLE;
      clr_state        <= C_IDLE;
      ramp_timer       <= '0;
      clr_timer        <= '0;
      clr_idx          <= '0;
      for (int unsigned i = 0; i < N; i++) retry[i] <= '0;
    end else begin
      error_sticky <= (error_sticky & ~{N{sticky_clr}}) | heater_error;
      active_count <= en_count;

      if (ramp_fire) begin
        ramp_state <= R_WAIT;
        ramp_timer <= TW'(STEP_CYCLES - 1);
        if (heater_error[ramp_k]) clr_pend[ramp_k] <= 1'b1;
        else                      heater_enable[ramp_k] <= 1'b1;
      end else if (ramp_state == R_WAIT) begin
        if (ramp_timer == '0) ramp_state <= R_IDLE;
        else                  ramp_timer <= ramp_timer - 1'b1;
      end

      for (int unsigned i = 0; i < N; i++) begin
        if (heater_error[i] && heater_enable[i]) begin
          heater_enable[i] <= 1'b0;
          clr_pend[i]      <= 1'b1;
        end
        if (!req_enable[i]) begin
          heater_enable[i] <= 1'b0;
          fault[i]         <= 1'b0;
          retry[i]         <= '0;
        end
      end

      case (clr_state)
        C_IDLE: if (pend_any) begin
          clr_idx          <= pend_k;
          clr_timer        <= TW'(CLEAR_CYCLES - 1);
          heater_err_clear <= N'(1) << pend_k;
          clr_state        <= C_PULSE;
        end
        C_PULSE: begin
          if (clr_timer == '0) begin
            heater_err_clear <= '0;
            clr_state        <= C_DONE;
          end else begin
            clr_timer <= clr_timer - 1'b1;
          end
        end
        C_DONE: begin
          clr_pend[clr_idx] <= 1'b0;
          if (req_enable[clr_idx]) begin
            retry[clr_idx] <= retry_next;
            if (retry_next == RW'(RETRY_MAX)) fault[clr_idx] <= 1'b1;
          end
          clr_state <= C_IDLE;
        end
        default: clr_state <= C_IDLE;
      endcase
    end
  end

endmodule
